os_drain_collector: RTL and testbench

OS_DRAIN_COLLECTOR -- requirements
Module: os_drain_collector

---
 rtl/pe_array_pkg.sv | 15 +
 rtl/drain_buf.sv | 27 ++
 rtl/os_drain_collector.sv | 126 ++++++++++++
 tb/tb_os_drain_collector.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE-array output path: collector FSM encoding
// and default operand/result widths.
package pe_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } drain_state_t;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_RESULT_WIDTH = 2 * DEFAULT_DATA_WIDTH;

endpackage

// File: rtl/drain_buf.sv
// Row-indexed result store for one drained column: one write port, one
// asynchronous read port. Contents are not reset.
module drain_buf
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROWS       = 4
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [$clog2(ROWS)-1:0]             waddr,
    input  logic signed [2*DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(ROWS)-1:0]             raddr,
    output logic signed [2*DATA_WIDTH-1:0]      rdata
);

    logic signed [2*DATA_WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/os_drain_collector.sv
// Drains one output-stationary PE column and streams its results top row first.
// Optional macro RESULT_RELU_EN clamps negative results to zero on the output.
module os_drain_collector
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROWS       = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic                                drain,
    input  logic signed [2*DATA_WIDTH-1:0]      col_in,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [2*DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(ROWS)-1:0]             out_row,
    output logic                                out_last,
    output logic                                done
);

    localparam int RW    = 2 * DATA_WIDTH;
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] PREV_ROW = ROW_W'(ROWS - 2);

    function automatic logic signed [RW-1:0] shape_result(input logic signed [RW-1:0] v);
`ifdef RESULT_RELU_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    drain_state_t          state;
    logic [ROW_W-1:0]      drain_cnt;
    logic [ROW_W-1:0]      cap_cnt;
    logic                  capture;
    logic [ROW_W-1:0]      waddr;
    logic signed [RW-1:0]  rd_data;

    // The bottom PE's value appears one cycle after drain first rises, so the
    // first DRAIN cycle captures nothing and CAPTURE picks up the final sample.
    assign capture = ((state == DRAIN) && (drain_cnt != '0)) || (state == CAPTURE);
    assign waddr   = LAST_ROW - cap_cnt;
    assign busy    = (state != IDLE);

    drain_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ROWS)
    ) u_buf (
        .clk   (clk),
        .we    (capture),
        .waddr (waddr),
        .wdata (col_in),
        .raddr (out_row),
        .rdata (rd_data)
    );

    // Gating on out_valid keeps stale buffer contents off the output.
    assign out_data = out_valid ? shape_result(rd_data) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain     <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= '0;
            cap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRAIN;
                        drain     <= 1'b1;
                        drain_cnt <= '0;
                        cap_cnt   <= '0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt != '0) begin
                        cap_cnt <= cap_cnt + 1'b1;
                    end
                    if (drain_cnt == LAST_ROW) begin
                        drain <= 1'b0;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    cap_cnt <= cap_cnt + 1'b1;
                    if (cap_cnt == LAST_ROW) begin
                        state     <= SEND;
                        cap_cnt   <= '0;
                        out_valid <= 1'b1;
                        out_row   <= '0;
                        out_last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_row   <= '0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_row  <= out_row + 1'b1;
                            out_last <= (out_row == PREV_ROW);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_os_drain_collector.sv
// Directed bench for os_drain_collector (ROWS=4, DATA_WIDTH=8), including a
// behavioural 4-PE output-stationary column feeding col_in.
module tb_os_drain_collector;
    import pe_array_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int RW = DEFAULT_RESULT_WIDTH;
    localparam int ROWS = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 drain;
    logic signed [RW-1:0] col_in;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [RW-1:0] out_data;
    logic [1:0]           out_row;
    logic                 out_last;
    logic                 done;

    int checks = 0;
    int errors = 0;

    // stimulus / collection state shared by run_op and the scenario tasks
    logic signed [RW-1:0] col_drv;
    logic                 use_pe;
    logic signed [RW-1:0] beat_data[$];
    int                   beat_row[$];
    logic                 beat_last[$];
    logic signed [RW-1:0] stall_data[$];
    int                   stall_rowq[$];
    int drain_cycles, first_drain, last_drain, first_valid, valid_cycles, done_cnt, done_cycle;

    // behavioural OS column: MAC when not draining, shift down when draining
    logic signed [RW-1:0] acc[ROWS];
    logic signed [RW-1:0] pe_down;
    logic                 pe_mac;
    logic signed [DW-1:0] pe_a[ROWS];
    logic signed [DW-1:0] pe_b;

    assign col_in = use_pe ? pe_down : col_drv;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (drain) begin
            pe_down <= acc[3];
            acc[3]  <= acc[2];
            acc[2]  <= acc[1];
            acc[1]  <= acc[0];
            acc[0]  <= '0;
        end else if (pe_mac) begin
            for (int r = 0; r < ROWS; r++) acc[r] <= acc[r] + RW'(pe_a[r]) * RW'(pe_b);
        end
    end

    os_drain_collector #(.DATA_WIDTH(DW), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .drain     (drain),
        .col_in    (col_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .done      (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Start one drain and run max_c cycles, presenting vals[0..3] on cycles 2..5.
    task automatic run_op(input logic signed [RW-1:0] vals[4], input int stall_row,
                          input int stall_n, input logic [31:0] extra_start, input int max_c);
        int stall_left;
        stall_left = stall_n;
        beat_data.delete(); beat_row.delete(); beat_last.delete();
        stall_data.delete(); stall_rowq.delete();
        drain_cycles = 0; first_drain = -1; last_drain = -1; first_valid = -1;
        valid_cycles = 0; done_cnt = 0; done_cycle = -1;
        start = 1'b1;
        tick();
        for (int c = 1; c <= max_c; c++) begin
            start   = extra_start[c];
            col_drv = (c >= 2 && c <= 5) ? vals[c-2] : 16'sh5A5A;
            if (drain) begin
                drain_cycles++;
                if (first_drain < 0) first_drain = c;
                last_drain = c;
            end
            out_ready = 1'b1;
            if (out_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = c;
                if (int'(out_row) == stall_row && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    stall_data.push_back(out_data);
                    stall_rowq.push_back(int'(out_row));
                end else begin
                    beat_data.push_back(out_data);
                    beat_row.push_back(int'(out_row));
                    beat_last.push_back(out_last);
                end
            end
            if (done) begin
                done_cnt++;
                done_cycle = c;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %b want 0", busy);
                end
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        start = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({drain, out_valid, out_last, done, busy} !== 5'b0 || out_data !== '0 || out_row !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: drain=%b valid=%b last=%b done=%b busy=%b data=%0d row=%0d want all 0",
                     drain, out_valid, out_last, done, busy, out_data, out_row);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || drain !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b drain=%b want 0 0", busy, drain);
        end
    endtask

    task automatic test_basic;
        logic signed [RW-1:0] v[4];
        logic signed [RW-1:0] exp_d[4];
        v = '{16'sd40, 16'sd30, 16'sd20, 16'sd10};
        exp_d = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
        run_op(v, -1, 0, 32'd0, 12);
        checks++;
        if (drain_cycles != 4 || first_drain != 1 || last_drain != 4) begin
            errors++;
            $display("FAIL basic_drain: cycles=%0d first=%0d last=%0d want 4 1 4", drain_cycles, first_drain, last_drain);
        end
        checks++;
        if (first_valid != 6 || valid_cycles != 4) begin
            errors++;
            $display("FAIL basic_send_window: first=%0d cycles=%0d want 6 4", first_valid, valid_cycles);
        end
        checks++;
        if (beat_data.size() != 4) begin
            errors++;
            $display("FAIL basic_beats: got %0d want 4", beat_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beat_data[i] !== exp_d[i] || beat_row[i] != i || beat_last[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL basic_beat%0d: data=%0d row=%0d last=%b want %0d %0d %b",
                             i, beat_data[i], beat_row[i], beat_last[i], exp_d[i], i, (i == 3));
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cycle != 10) begin
            errors++;
            $display("FAIL basic_done: count=%0d cycle=%0d want 1 10", done_cnt, done_cycle);
        end
    endtask

    task automatic test_backpressure;
        logic signed [RW-1:0] v[4];
        v = '{16'sd40, 16'sd30, 16'sd20, 16'sd10};
        run_op(v, 1, 3, 32'd0, 18);
        checks++;
        if (beat_data.size() != 4) begin
            errors++;
            $display("FAIL bp_beats: got %0d want 4", beat_data.size());
        end else begin
            checks++;
            if (beat_data[0] !== 16'sd10 || beat_data[1] !== 16'sd20 || beat_data[2] !== 16'sd30
                || beat_data[3] !== 16'sd40 || beat_row[1] != 1 || beat_last[3] !== 1'b1) begin
                errors++;
                $display("FAIL bp_order: got %0d %0d %0d %0d want 10 20 30 40",
                         beat_data[0], beat_data[1], beat_data[2], beat_data[3]);
            end
        end
        checks++;
        if (stall_data.size() != 3) begin
            errors++;
            $display("FAIL bp_stalls: got %0d want 3", stall_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (stall_data[i] !== 16'sd20 || stall_rowq[i] != 1) begin
                    errors++;
                    $display("FAIL bp_hold%0d: data=%0d row=%0d want 20 1", i, stall_data[i], stall_rowq[i]);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_cycle != 13 || valid_cycles != 7) begin
            errors++;
            $display("FAIL bp_done: count=%0d cycle=%0d valid=%0d want 1 13 7", done_cnt, done_cycle, valid_cycles);
        end
    endtask

    task automatic test_sign;
        logic signed [RW-1:0] v[4];
        logic signed [RW-1:0] exp3, exp1;
        v = '{-16'sd300, 16'sd5, -16'sd7, 16'sd32767};
`ifdef RESULT_RELU_EN
        exp3 = 16'sd0;
        exp1 = 16'sd0;
`else
        exp3 = -16'sd300;
        exp1 = -16'sd7;
`endif
        run_op(v, -1, 0, 32'd0, 12);
        checks++;
        if (beat_data.size() != 4) begin
            errors++;
            $display("FAIL sign_beats: got %0d want 4", beat_data.size());
        end else begin
            checks++;
            if (beat_data[3] !== exp3 || beat_data[1] !== exp1) begin
                errors++;
                $display("FAIL sign_rows: row3=%0d row1=%0d want %0d %0d", beat_data[3], beat_data[1], exp3, exp1);
            end
            checks++;
            if (beat_data[0] !== 16'sd32767 || beat_data[2] !== 16'sd5) begin
                errors++;
                $display("FAIL sign_pos: row0=%0d row2=%0d want 32767 5", beat_data[0], beat_data[2]);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic signed [RW-1:0] v[4];
        logic [31:0] extra;
        v = '{16'sd4, 16'sd3, 16'sd2, 16'sd1};
        extra = 32'd0;
        extra[2] = 1'b1;
        extra[7] = 1'b1;
        run_op(v, -1, 0, extra, 14);
        checks++;
        if (drain_cycles != 4 || done_cnt != 1 || beat_data.size() != 4) begin
            errors++;
            $display("FAIL start_ignored: drains=%0d dones=%0d beats=%0d want 4 1 4",
                     drain_cycles, done_cnt, beat_data.size());
        end
    endtask

    task automatic test_back_to_back;
        logic signed [RW-1:0] v[4];
        logic [31:0] extra;
        v = '{16'sd4, 16'sd3, 16'sd2, 16'sd1};
        extra = 32'd0;
        extra[10] = 1'b1;
        run_op(v, -1, 0, extra, 11);
        checks++;
        if (done_cycle != 10 || drain_cycles != 5 || last_drain != 11) begin
            errors++;
            $display("FAIL back_to_back: done=%0d drains=%0d last=%0d want 10 5 11",
                     done_cycle, drain_cycles, last_drain);
        end
        do_reset();
    endtask

    task automatic test_mid_reset;
        int bad;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (drain !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: drain=%b valid=%b busy=%b want 0 0 0", drain, out_valid, busy);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid || drain || done) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: active cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_pe_column;
        logic signed [RW-1:0] v[4];
        logic signed [RW-1:0] gold[4];
        logic signed [DW-1:0] bs[3];
        v = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        // a = 1,2,3,-4 ; b = 5,6,7 -> per-row sums 18,36,54,-72
        pe_a = '{8'sd1, 8'sd2, 8'sd3, -8'sd4};
        bs   = '{8'sd5, 8'sd6, 8'sd7};
`ifdef RESULT_RELU_EN
        gold = '{16'sd18, 16'sd36, 16'sd54, 16'sd0};
`else
        gold = '{16'sd18, 16'sd36, 16'sd54, -16'sd72};
`endif
        for (int k = 0; k < 3; k++) begin
            pe_b = bs[k];
            pe_mac = 1'b1;
            tick();
        end
        pe_mac = 1'b0;
        use_pe = 1'b1;
        run_op(v, -1, 0, 32'd0, 12);
        use_pe = 1'b0;
        checks++;
        if (beat_data.size() != 4) begin
            errors++;
            $display("FAIL pe_beats: got %0d want 4", beat_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beat_data[i] !== gold[i]) begin
                    errors++;
                    $display("FAIL pe_row%0d: got %0d want %0d", i, beat_data[i], gold[i]);
                end
            end
        end
        checks++;
        if (acc[0] !== '0 || acc[1] !== '0 || acc[2] !== '0 || acc[3] !== '0) begin
            errors++;
            $display("FAIL pe_cleared: acc=%0d %0d %0d %0d want 0 0 0 0", acc[0], acc[1], acc[2], acc[3]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        col_drv = '0;
        use_pe = 1'b0;
        pe_mac = 1'b0;
        pe_b = '0;
        pe_down = '0;
        for (int r = 0; r < ROWS; r++) begin
            acc[r] = '0;
            pe_a[r] = '0;
        end
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_sign();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        test_pe_column();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
